// File: rtl/select_first_pkg.sv
// Shared widths, item types and extension helpers for the select-first stage.
package select_first_pkg;

  localparam int unsigned N_CH = 4;   // request channels, index 0 = highest priority
  localparam int unsigned DW   = 11;  // signed output width
  localparam int unsigned IW   = 4;   // signed channel width
  localparam int unsigned DFW  = 8;   // unsigned default-source width

  // One-hot source select; bit N_CH marks the default source.
  typedef logic [N_CH:0] sel_t;

  typedef struct packed {
    logic [DW-1:0] data;
    sel_t          sel;
  } item_t;

  // Sign-extend a channel value to the output width.
  function automatic logic [DW-1:0] sext_iw(input logic [IW-1:0] v);
    return {{(DW-IW){v[IW-1]}}, v};
  endfunction

  // Zero-extend the default value to the output width.
  function automatic logic [DW-1:0] zext_dfw(input logic [DFW-1:0] v);
    return {{(DW-DFW){1'b0}}, v};
  endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-entry valid/ready buffer: output register plus one skid register.
// Latency 1, full throughput; the skid entry absorbs one item under backpressure.
module skid_buf
  import select_first_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  output logic  in_ready,
  input  item_t in_item,
  output logic  out_valid,
  input  logic  out_ready,
  output item_t out_item
);

  logic  rdy_q;         // low through the reset-release cycle so no handshake lands on it
  logic  out_valid_q;
  item_t out_item_q;
  logic  skid_valid_q;
  item_t skid_item_q;
  logic  in_xfer;
  logic  out_free;

  assign in_ready  = rdy_q & ~skid_valid_q;
  assign in_xfer   = in_valid & in_ready;
  assign out_free  = ~out_valid_q | out_ready;
  assign out_valid = out_valid_q;
  assign out_item  = out_item_q;

  // Output register refills from skid first, else directly from the input; else skid catches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_item_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_item_q  <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (out_free) begin
        if (skid_valid_q) begin
          out_valid_q  <= 1'b1;
          out_item_q   <= skid_item_q;
          skid_valid_q <= 1'b0;
        end else if (in_xfer) begin
          out_valid_q <= 1'b1;
          out_item_q  <= in_item;
        end else begin
          out_valid_q <= 1'b0;
        end
      end else if (in_xfer) begin
        skid_valid_q <= 1'b1;
        skid_item_q  <= in_item;
      end
    end
  end

endmodule

// File: rtl/select_first_stage.sv
// Strict-priority picker over N_CH channels plus a default source, feeding a skid buffer.
// Optional per-source grant counters when SELECT_FIRST_STAGE_STATS_EN is defined.
module select_first_stage
  import select_first_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CH-1:0]    in_valid,
  output logic [N_CH-1:0]    in_ready,
  input  logic [N_CH*IW-1:0] in_data,
  input  logic               dflt_valid,
  output logic               dflt_ready,
  input  logic [DFW-1:0]     dflt_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_data,
  output logic [N_CH:0]      out_sel
`ifdef SELECT_FIRST_STAGE_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [N_CH:0][15:0] stat_grants
`endif
);

  sel_t  grant;
  item_t pick;
  logic  any_grant;
  logic  accept;
  item_t buf_out;

  // Lowest-index valid channel wins; default only when no channel is valid.
  always_comb begin
    grant = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (in_valid[i] && (grant == '0)) grant[i] = 1'b1;
    end
    if ((grant == '0) && dflt_valid) grant[N_CH] = 1'b1;
  end

  // Build the item for the granted source.
  always_comb begin
    pick.data = '0;
    pick.sel  = grant;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) pick.data = sext_iw(in_data[i*IW +: IW]);
    end
    if (grant[N_CH]) pick.data = zext_dfw(dflt_data);
  end

  assign any_grant  = |grant;
  assign in_ready   = grant[N_CH-1:0] & {N_CH{accept}};
  assign dflt_ready = grant[N_CH] & accept;

  skid_buf u_skid_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (any_grant),
    .in_ready  (accept),
    .in_item   (pick),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_item  (buf_out)
  );

  assign out_data = buf_out.data;
  assign out_sel  = buf_out.sel;

`ifdef SELECT_FIRST_STAGE_STATS_EN
  sel_t xfer;
  assign xfer = grant & {(N_CH+1){accept}};

  // Saturating per-source grant counters; clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_grants <= '0;
    end else if (stat_clr) begin
      stat_grants <= '0;
    end else begin
      for (int i = 0; i <= N_CH; i++) begin
        if (xfer[i] && (stat_grants[i] != 16'hFFFF)) stat_grants[i] <= stat_grants[i] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_select_first_stage.sv
// Directed bench for select_first_stage: reset, priority, default, backpressure, throughput, stats.
module tb_select_first_stage;
  import select_first_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_CH-1:0]    in_valid;
  logic [N_CH-1:0]    in_ready;
  logic [N_CH*IW-1:0] in_data;
  logic               dflt_valid;
  logic               dflt_ready;
  logic [DFW-1:0]     dflt_data;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;
  logic [N_CH:0]      out_sel;
`ifdef SELECT_FIRST_STAGE_STATS_EN
  logic               stat_clr;
  logic [N_CH:0][15:0] stat_grants;
`endif

  int total = 0;
  int fails = 0;

  select_first_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .dflt_valid (dflt_valid),
    .dflt_ready (dflt_ready),
    .dflt_data  (dflt_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sel    (out_sel)
`ifdef SELECT_FIRST_STAGE_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .stat_grants(stat_grants)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  tp_in  [6];
  logic [10:0] tp_exp [6];

  initial begin
    tp_in  = '{4'h0, 4'h7, 4'h8, 4'hF, 4'h1, 4'h9};
    tp_exp = '{11'h000, 11'h007, 11'h7F8, 11'h7FF, 11'h001, 11'h7F9};

    // 1: reset with every channel requesting
    rst        = 1'b0;
    in_valid   = 4'hF;
    in_data    = 16'h0006;
    dflt_valid = 1'b0;
    dflt_data  = 8'h00;
    out_ready  = 1'b1;
`ifdef SELECT_FIRST_STAGE_STATS_EN
    stat_clr   = 1'b0;
`endif
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_dflt_ready", 32'(dflt_ready), 32'd0);
    tick();
    tick();
    chk("rst_held_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd0);
    tick();  // reset-release edge: nothing transfers
    chk("release_no_xfer", 32'(out_valid), 32'd0);
    chk("first_grant_ready", 32'(in_ready), 32'b0001);
    tick();
    chk("first_grant_valid", 32'(out_valid), 32'd1);
    chk("first_grant_sel", 32'(out_sel), 32'b00001);
    chk("first_grant_data", 32'(out_data), 32'd6);
    in_valid = 4'h0;
    tick();
    chk("drain_empty", 32'(out_valid), 32'd0);

    // 2: priority, ch1 beats ch3
    in_valid = 4'b1010;
    in_data  = 16'h50D0;  // ch3=5, ch1=-3
    #1;
    chk("prio_in_ready", 32'(in_ready), 32'b0010);
    tick();
    chk("prio_data", 32'(out_data), 32'h7FD);
    chk("prio_sel", 32'(out_sel), 32'b00010);
    in_valid = 4'h0;

    // 3: default source, loaded while previous item drains
    dflt_valid = 1'b1;
    dflt_data  = 8'hC8;
    #1;
    chk("dflt_ready", 32'(dflt_ready), 32'd1);
    chk("dflt_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("dflt_valid_out", 32'(out_valid), 32'd1);
    chk("dflt_data", 32'(out_data), 32'd200);
    chk("dflt_sel", 32'(out_sel), 32'b10000);
    dflt_valid = 1'b0;
    tick();
    chk("dflt_drained", 32'(out_valid), 32'd0);

    // 4: backpressure on ch2 stream 1,2,3
    in_valid = 4'b0100;
    in_data  = 16'h0100;
    tick();
    chk("bp_first", 32'(out_data), 32'd1);
    out_ready = 1'b0;
    in_data   = 16'h0200;
    #1;
    chk("bp_skid_ready", 32'(in_ready), 32'b0100);
    tick();
    in_data = 16'h0300;
    #1;
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_data", 32'(out_data), 32'd1);
    chk("bp_hold_sel", 32'(out_sel), 32'b00100);
    tick();
    chk("bp_hold2_data", 32'(out_data), 32'd1);
    chk("bp_hold2_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_out2", 32'(out_data), 32'd2);
    chk("bp_out2_ready", 32'(in_ready), 32'b0100);
    tick();
    chk("bp_out3", 32'(out_data), 32'd3);
    chk("bp_out3_valid", 32'(out_valid), 32'd1);
    in_valid = 4'h0;
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // 5: full throughput on ch0 with sign extension
    in_valid = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      in_data = {12'h000, tp_in[k]};
      tick();
      chk("tp_valid", 32'(out_valid), 32'd1);
      chk("tp_data", 32'(out_data), 32'(tp_exp[k]));
    end
    in_valid = 4'h0;
    tick();

    // Reset while both entries are occupied
    in_valid  = 4'b0001;
    in_data   = 16'h0007;
    out_ready = 1'b0;
    tick();
    tick();
    chk("mid_full_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("mid_release_valid", 32'(out_valid), 32'd0);
    tick();
    chk("mid_after_data", 32'(out_data), 32'd7);
    in_valid = 4'h0;
    tick();
    chk("mid_no_dup", 32'(out_valid), 32'd0);

`ifdef SELECT_FIRST_STAGE_STATS_EN
    // 6: grant counters
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    in_valid = 4'b0010;
    tick();
    tick();
    tick();
    in_valid   = 4'h0;
    dflt_valid = 1'b1;
    tick();
    dflt_valid = 1'b0;
    chk("stat_ch1", 32'(stat_grants[1]), 32'd3);
    chk("stat_dflt", 32'(stat_grants[4]), 32'd1);
    chk("stat_ch0", 32'(stat_grants[0]), 32'd0);
    in_valid = 4'b0001;
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    in_valid = 4'h0;
    chk("stat_clr_ch0", 32'(stat_grants[0]), 32'd0);
    chk("stat_clr_ch1", 32'(stat_grants[1]), 32'd0);
    in_valid = 4'b0001;
    repeat (70000) tick();
    in_valid = 4'h0;
    chk("stat_sat", 32'(stat_grants[0]), 32'h0000FFFF);
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
